// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch -- fetches one- or two-word instructions into IR/IF_imm.
// Revision 1.0
// ============================================================================
`default_nettype none

module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        IF_Ins_load,
  input  logic        IF_PC_load,
  input  logic [15:0] IF_PC_target,
  input  logic        IF_PC_inc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [3:0]  IF_opcode,
  output logic [3:0]  IF_dst,
  output logic [3:0]  IF_src,
  output logic [15:0] IF_imm,
  output logic        IF_ins_valid,
  output logic        IF_busy,
  output logic [15:0] IF_pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] OP_TWO_WORD = 4'b0001;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] imm_q, imm_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    if (!en) begin
      // Abort: drop back to IDLE, keep PC/IR/imm so nothing is half-consumed
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (IF_PC_load)
            pc_d = IF_PC_target;
          else if (IF_PC_inc)
            pc_d = pc_q + 16'd1;
          if (IF_Ins_load)
            state_d = FETCH1;
        end
        FETCH1: begin
          if (mem_rvalid) begin
            ir_d = mem_rdata;
            pc_d = pc_q + 16'd1;
            if (mem_rdata[15:12] == OP_TWO_WORD) begin
              state_d = FETCH2;
            end else begin
              imm_d   = 16'd0;
              state_d = HOLD;
            end
          end
        end
        FETCH2: begin
          if (mem_rvalid) begin
            imm_d   = mem_rdata;
            pc_d    = pc_q + 16'd1;
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    mem_req_d = (state_d == FETCH1) || (state_d == FETCH2);
    busy_d    = mem_req_d;
    valid_d   = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= 16'd0;
      ir_q      <= 16'd0;
      imm_q     <= 16'd0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  // PC is frozen during a fetch, so it doubles as the stable read address
  assign mem_addr     = pc_q;
  assign mem_req      = mem_req_q;
  assign IF_busy      = busy_q;
  assign IF_ins_valid = valid_q;
  assign IF_pc        = pc_q;
  assign IF_imm       = imm_q;
  assign IF_opcode    = ir_q[15:12];
  assign IF_dst       = ir_q[11:8];
  assign IF_src       = ir_q[7:4];

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch -- directed self-checking bench for instruction_fetch.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        IF_Ins_load;
  logic        IF_PC_load;
  logic [15:0] IF_PC_target;
  logic        IF_PC_inc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  IF_opcode;
  logic [3:0]  IF_dst;
  logic [3:0]  IF_src;
  logic [15:0] IF_imm;
  logic        IF_ins_valid;
  logic        IF_busy;
  logic [15:0] IF_pc;

  logic [15:0] mem [0:15];
  logic        rv_ok;
  logic        stray;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[3:0]];
  assign mem_rvalid = (mem_req & rv_ok) | stray;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .IF_Ins_load  (IF_Ins_load),
    .IF_PC_load   (IF_PC_load),
    .IF_PC_target (IF_PC_target),
    .IF_PC_inc    (IF_PC_inc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .IF_opcode    (IF_opcode),
    .IF_dst       (IF_dst),
    .IF_src       (IF_src),
    .IF_imm       (IF_imm),
    .IF_ins_valid (IF_ins_valid),
    .IF_busy      (IF_busy),
    .IF_pc        (IF_pc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic req, input logic busy, input logic valid);
    chk({tag, ".mem_req"}, {15'd0, mem_req}, {15'd0, req});
    chk({tag, ".busy"},    {15'd0, IF_busy}, {15'd0, busy});
    chk({tag, ".valid"},   {15'd0, IF_ins_valid}, {15'd0, valid});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0A50;
    mem[1] = 16'h1300;
    mem[2] = 16'hBEEF;
    mem[3] = 16'h2345;
    rst_n = 1'b0; en = 1'b1; IF_Ins_load = 1'b0; IF_PC_load = 1'b0;
    IF_PC_target = 16'h0000; IF_PC_inc = 1'b0; rv_ok = 1'b1; stray = 1'b0;

    // Reset values
    #3;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.pc", IF_pc, 16'h0000);
    chk("rst.addr", mem_addr, 16'h0000);
    chk("rst.imm", IF_imm, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-word fetch, zero-wait
    IF_Ins_load = 1'b1; tick(); IF_Ins_load = 1'b0;
    chk_ctl("f1a", 1'b1, 1'b1, 1'b0);
    chk("f1a.addr", mem_addr, 16'h0000);
    tick();
    chk_ctl("f1b", 1'b0, 1'b0, 1'b1);
    chk("f1b.op", {12'd0, IF_opcode}, 16'h0000);
    chk("f1b.dst", {12'd0, IF_dst}, 16'h000A);
    chk("f1b.src", {12'd0, IF_src}, 16'h0005);
    chk("f1b.imm", IF_imm, 16'h0000);
    chk("f1b.pc", IF_pc, 16'h0001);

    // Two-word fetch
    IF_Ins_load = 1'b1; tick(); IF_Ins_load = 1'b0;
    chk_ctl("f2a", 1'b1, 1'b1, 1'b0);
    chk("f2a.addr", mem_addr, 16'h0001);
    tick();
    chk_ctl("f2b", 1'b1, 1'b1, 1'b0);
    chk("f2b.addr", mem_addr, 16'h0002);
    tick();
    chk_ctl("f2c", 1'b0, 1'b0, 1'b1);
    chk("f2c.op", {12'd0, IF_opcode}, 16'h0001);
    chk("f2c.dst", {12'd0, IF_dst}, 16'h0003);
    chk("f2c.imm", IF_imm, 16'hBEEF);
    chk("f2c.pc", IF_pc, 16'h0003);

    // Delayed response; requests during the wait are ignored
    rv_ok = 1'b0;
    IF_Ins_load = 1'b1; tick(); IF_Ins_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("wait%0d", i), 1'b1, 1'b1, 1'b0);
      chk($sformatf("wait%0d.addr", i), mem_addr, 16'h0003);
      IF_Ins_load = 1'b1; IF_PC_load = 1'b1; IF_PC_target = 16'h0040;
      tick();
      IF_Ins_load = 1'b0; IF_PC_load = 1'b0;
    end
    chk_ctl("wait3", 1'b1, 1'b1, 1'b0);
    chk("wait3.addr", mem_addr, 16'h0003);
    rv_ok = 1'b1;
    tick();
    chk_ctl("dly", 1'b0, 1'b0, 1'b1);
    chk("dly.op", {12'd0, IF_opcode}, 16'h0002);
    chk("dly.imm", IF_imm, 16'h0000);
    chk("dly.pc", IF_pc, 16'h0004);
    tick();
    chk_ctl("noqueue", 1'b0, 1'b0, 1'b1);

    // Stray rvalid in HOLD
    stray = 1'b1; tick(); stray = 1'b0;
    chk("stray.op", {12'd0, IF_opcode}, 16'h0002);
    chk("stray.pc", IF_pc, 16'h0004);

    // PC wrap and load-beats-increment
    IF_PC_load = 1'b1; IF_PC_target = 16'hFFFF; tick(); IF_PC_load = 1'b0;
    chk("ld.pc", IF_pc, 16'hFFFF);
    chk_ctl("ld", 1'b0, 1'b0, 1'b1);
    IF_PC_inc = 1'b1; tick(); IF_PC_inc = 1'b0;
    chk("wrap.pc", IF_pc, 16'h0000);
    IF_PC_load = 1'b1; IF_PC_inc = 1'b1; IF_PC_target = 16'h0040; tick();
    IF_PC_load = 1'b0; IF_PC_inc = 1'b0;
    chk("ldinc.pc", IF_pc, 16'h0040);

    // Jump and fetch in the same cycle
    IF_PC_load = 1'b1; IF_PC_target = 16'h0002; IF_Ins_load = 1'b1; tick();
    IF_PC_load = 1'b0; IF_Ins_load = 1'b0;
    chk("jf.addr", mem_addr, 16'h0002);
    tick();
    chk("jf.op", {12'd0, IF_opcode}, 16'h000B);
    chk("jf.imm", IF_imm, 16'h0000);
    chk("jf.pc", IF_pc, 16'h0003);

    // en=0 during FETCH2
    IF_PC_load = 1'b1; IF_PC_target = 16'h0001; IF_Ins_load = 1'b1; tick();
    IF_PC_load = 1'b0; IF_Ins_load = 1'b0;
    chk("en.f1addr", mem_addr, 16'h0001);
    tick();
    chk("en.f2addr", mem_addr, 16'h0002);
    rv_ok = 1'b0; en = 1'b0; tick();
    chk_ctl("abort", 1'b0, 1'b0, 1'b0);
    chk("abort.pc", IF_pc, 16'h0002);
    chk("abort.op", {12'd0, IF_opcode}, 16'h0001);
    en = 1'b1; rv_ok = 1'b1; tick();
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);

    // Async reset mid-FETCH1
    rv_ok = 1'b0;
    IF_Ins_load = 1'b1; tick(); IF_Ins_load = 1'b0;
    chk_ctl("prerst", 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("arst", 1'b0, 1'b0, 1'b0);
    chk("arst.pc", IF_pc, 16'h0000);
    chk("arst.addr", mem_addr, 16'h0000);
    chk("arst.op", {12'd0, IF_opcode}, 16'h0000);
    chk("arst.imm", IF_imm, 16'h0000);
    tick();
    rst_n = 1'b1; rv_ok = 1'b1; stray = 1'b1;
    tick();
    stray = 1'b0;
    chk_ctl("post", 1'b0, 1'b0, 1'b0);
    chk("post.pc", IF_pc, 16'h0000);
    chk("post.op", {12'd0, IF_opcode}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk is the only clock; rst_n is an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: en  input  1  block enable; 0 = abort and hold in IDLE.
REQ-005 Port: IF_Ins_load  input  1  one-cycle fetch request from the control FSM.
REQ-006 Port: IF_PC_load  input  1  load PC from IF_PC_target (jump).
REQ-007 Port: IF_PC_target  input  16  jump target address.
REQ-008 Port: IF_PC_inc  input  1  increment PC by 1 (skip) without fetching.
REQ-009 Port: mem_req  output  1  program-memory read request.
REQ-010 Port: mem_addr  output  16  program-memory read address.
REQ-011 Port: mem_rdata  input  16  program-memory read data.
REQ-012 Port: mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-013 Port: IF_opcode  output  4  IR[15:12], drives the control FSM opcode input.
REQ-014 Port: IF_dst, IF_src  output  4 each  IR[11:8], IR[7:4].
REQ-015 Port: IF_imm  output  16  second instruction word for two-word opcodes; 0 otherwise.
REQ-016 Port: IF_ins_valid  output  1  IR/IF_imm hold a complete instruction.
REQ-017 Port: IF_busy  output  1  fetch in progress.
REQ-018 Port: IF_pc  output  16  current PC.

Function
REQ-019 FSM states SHALL be IDLE, FETCH1, FETCH2, HOLD.
REQ-020 IDLE or HOLD + IF_Ins_load=1 -> FETCH1 next cycle; IF_ins_valid deasserts the same edge.
REQ-021 FETCH1/FETCH2: mem_req=1; mem_addr=PC, held stable until mem_rvalid; IF_busy=1.
REQ-022 FETCH1 + mem_rvalid: IR <= mem_rdata, PC <= PC+1; if mem_rdata[15:12]=4'b0001 -> FETCH2, else IF_imm <= 0 and -> HOLD.
REQ-023 FETCH2 + mem_rvalid: IF_imm <= mem_rdata, PC <= PC+1, -> HOLD.
REQ-024 HOLD: IF_ins_valid=1, mem_req=0, IR/IF_imm stable until next fetch.
REQ-025 mem_rvalid outside FETCH1/FETCH2 SHALL be ignored.
REQ-026 IF_Ins_load, IF_PC_load, IF_PC_inc while IF_busy=1 SHALL be ignored (not queued).
REQ-027 In IDLE/HOLD: IF_PC_load -> PC <= IF_PC_target; IF_PC_inc -> PC <= PC+1; both asserted -> load wins.
REQ-028 IF_Ins_load together with IF_PC_load/IF_PC_inc in IDLE/HOLD: PC update applies first; fetch uses updated PC next cycle.
REQ-029 PC arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000, no flag.
REQ-030 en=0 at a clock edge: state -> IDLE, mem_req=0 next cycle, IF_ins_valid=0, PC/IR/IF_imm retained; no PC increment for an aborted word.
REQ-031 Latency: single-word instruction with zero-wait memory (mem_rvalid in first FETCH1 cycle) -> IF_ins_valid 2 cycles after IF_Ins_load; two-word -> 3 cycles.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, PC=0, IR=0, IF_imm=0, mem_req=0, mem_addr=0, IF_ins_valid=0, IF_busy=0, IF_opcode/IF_dst/IF_src=0.
REQ-033 Reset asserted mid-fetch SHALL abandon the fetch; a mem_rvalid arriving after reset release with no request SHALL be ignored.

Verification
REQ-034 Reset, zero-wait memory, word 0 = 16'h0A50, IF_Ins_load pulse -> mem_addr=0, IR=16'h0A50, IF_opcode=0, IF_imm=0, IF_ins_valid after 2 cycles, PC=1.
REQ-035 Word 1 = 16'h1300, word 2 = 16'hBEEF, fetch from PC=1 -> two requests (addr 1, 2), IF_opcode=1, IF_imm=16'hBEEF, PC=3.
REQ-036 mem_rvalid delayed 3 cycles -> mem_req and mem_addr held constant 3 cycles, IF_busy=1 throughout; IF_Ins_load pulsed during wait has no effect.
REQ-037 PC=16'hFFFF, IF_PC_inc=1 -> PC=16'h0000; in HOLD, IF_PC_load=1 + IF_PC_inc=1 + target 16'h0040 -> PC=16'h0040.
REQ-038 en=0 during FETCH2 -> IDLE, mem_req=0, IF_ins_valid=0, PC still pointing at immediate word; rst_n low mid-FETCH1 -> all outputs 0 without a clock edge.
